// File: rtl/morty_mem_arbiter.sv
// Purpose : shares one Wishbone-style memory port between the instruction-fetch
//           port (iport) and the data port (dport). Data and instruction take turns
//           when both request. One bus transaction is open at a time, and a watchdog
//           turns a hung bus into a fault.
// Latency : the grant is sampled at edge N and the bus cycle opens at N+1. The slave's
//           ack/err is sampled at edge M and the completion pulse is issued at M+1.
//           Back-to-back transactions complete at most one per 3 cycles.
// Backpr. : a requester holds req until it sees its ack/err pulse. The other requester
//           waits in req until the arbiter returns to idle and grants it.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   iport_*                 instruction fetch: req/addr in, rdata/ack/err out
//   dport_*                 data access: req/addr/wdata/sel/we in, rdata/ack/err out
//   wb_*                    registered Wishbone master: cyc/stb/we/addr/dat/sel out,
//                           dat/ack/err in
module morty_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        iport_req_i,
    input  logic [31:0] iport_addr_i,
    output logic [31:0] iport_rdata_o,
    output logic        iport_ack_o,
    output logic        iport_err_o,

    input  logic        dport_req_i,
    input  logic [31:0] dport_addr_i,
    input  logic [31:0] dport_wdata_i,
    input  logic [3:0]  dport_sel_i,
    input  logic        dport_we_i,
    output logic [31:0] dport_rdata_o,
    output logic        dport_ack_o,
    output logic        dport_err_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_addr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IBUS = 2'd1,
        S_DBUS = 2'd2
    } state_t;

    // Watchdog count at which an unanswered bus cycle is given up.
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last_d;      // 1: the most recent grant went to the data port
    logic [15:0] r_wdog;

    logic        r_wb_we;
    logic [31:0] r_wb_addr;
    logic [31:0] r_wb_dat;
    logic [3:0]  r_wb_sel;

    logic [31:0] r_irdata;
    logic [31:0] r_drdata;
    logic        r_iack;
    logic        r_ierr;
    logic        r_dack;
    logic        r_derr;

    logic        w_bus_open;
    logic        w_pulse_out;
    logic        w_wdog_exp;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_done_ok;
    logic        w_done_err;

    assign w_bus_open  = (r_state != S_IDLE);

    // While a completion pulse is out, the finishing requester still holds its req.
    // That req must not be taken as a new request. No grant is made in this cycle.
    assign w_pulse_out = r_iack | r_ierr | r_dack | r_derr;

    // The watchdog expires only when the slave gives no answer in the final cycle.
    // A response in that same cycle takes precedence over the timeout.
    assign w_wdog_exp  = w_bus_open && !wb_ack_i && !wb_err_i && (r_wdog == WDOG_LAST);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = S_DBUS;
                end else if (w_grant_i) begin
                    w_state_nxt = S_IBUS;
                end
            end
            S_IBUS, S_DBUS: begin
                if (w_done_ok || w_done_err) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode: grant and completion decisions
    // ---------------------------------------------------------------------
    always_comb begin
        w_grant_i  = 1'b0;
        w_grant_d  = 1'b0;
        w_done_ok  = 1'b0;
        w_done_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_pulse_out) begin
                    if (dport_req_i && iport_req_i) begin
                        // Under contention, the requester that was not served last wins.
                        w_grant_i = r_last_d;
                        w_grant_d = !r_last_d;
                    end else begin
                        w_grant_d = dport_req_i;
                        w_grant_i = iport_req_i;
                    end
                end
            end
            S_IBUS, S_DBUS: begin
                // A bus error overrides a simultaneous ack.
                if (wb_err_i || w_wdog_exp) begin
                    w_done_err = 1'b1;
                end else if (wb_ack_i) begin
                    w_done_ok = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: bus latches, watchdog, completion pulses, read data
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_d  <= 1'b0;
            r_wdog    <= 16'd0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= 32'd0;
            r_wb_dat  <= 32'd0;
            r_wb_sel  <= 4'd0;
            r_irdata  <= 32'd0;
            r_drdata  <= 32'd0;
            r_iack    <= 1'b0;
            r_ierr    <= 1'b0;
            r_dack    <= 1'b0;
            r_derr    <= 1'b0;
        end else begin
            r_iack <= w_done_ok  && (r_state == S_IBUS);
            r_ierr <= w_done_err && (r_state == S_IBUS);
            r_dack <= w_done_ok  && (r_state == S_DBUS);
            r_derr <= w_done_err && (r_state == S_DBUS);

            if (w_grant_i) begin
                r_wb_addr <= iport_addr_i;
                r_wb_we   <= 1'b0;
                r_wb_sel  <= 4'hF;
                r_wb_dat  <= 32'd0;
                r_wdog    <= 16'd0;
                r_last_d  <= 1'b0;
            end else if (w_grant_d) begin
                r_wb_addr <= dport_addr_i;
                r_wb_we   <= dport_we_i;
                r_wb_sel  <= dport_sel_i;
                r_wb_dat  <= dport_wdata_i;
                r_wdog    <= 16'd0;
                r_last_d  <= 1'b1;
            end else if (w_bus_open) begin
                r_wdog <= r_wdog + 16'd1;
            end

            // Fetches and loads capture read data. Stores leave it untouched.
            if (w_done_ok && (r_state == S_IBUS)) begin
                r_irdata <= wb_dat_i;
            end
            if (w_done_ok && (r_state == S_DBUS) && !r_wb_we) begin
                r_drdata <= wb_dat_i;
            end
        end
    end

    // cyc and stb are both taken from the state flop, so they rise and fall together.
    assign wb_cyc_o      = w_bus_open;
    assign wb_stb_o      = w_bus_open;
    assign wb_we_o       = r_wb_we;
    assign wb_addr_o     = r_wb_addr;
    assign wb_dat_o      = r_wb_dat;
    assign wb_sel_o      = r_wb_sel;

    assign iport_rdata_o = r_irdata;
    assign iport_ack_o   = r_iack;
    assign iport_err_o   = r_ierr;
    assign dport_rdata_o = r_drdata;
    assign dport_ack_o   = r_dack;
    assign dport_err_o   = r_derr;

endmodule

// File: tb/tb_morty_mem_arbiter.sv
// Purpose : directed self-checking bench for morty_mem_arbiter (TIMEOUT_CYCLES = 8).
// Latency : inputs are driven and outputs sampled 1 ns after each rising edge.
// Backpr. : the bench acts as both requesters and as the Wishbone slave.
module tb_morty_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        iport_req_i;
    logic [31:0] iport_addr_i;
    logic [31:0] iport_rdata_o;
    logic        iport_ack_o;
    logic        iport_err_o;
    logic        dport_req_i;
    logic [31:0] dport_addr_i;
    logic [31:0] dport_wdata_i;
    logic [3:0]  dport_sel_i;
    logic        dport_we_i;
    logic [31:0] dport_rdata_o;
    logic        dport_ack_o;
    logic        dport_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    morty_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iport_req_i(iport_req_i), .iport_addr_i(iport_addr_i),
        .iport_rdata_o(iport_rdata_o), .iport_ack_o(iport_ack_o), .iport_err_o(iport_err_o),
        .dport_req_i(dport_req_i), .dport_addr_i(dport_addr_i), .dport_wdata_i(dport_wdata_i),
        .dport_sel_i(dport_sel_i), .dport_we_i(dport_we_i),
        .dport_rdata_o(dport_rdata_o), .dport_ack_o(dport_ack_o), .dport_err_o(dport_err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, iport_ack_o, iport_err_o, dport_ack_o, dport_err_o} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got cyc=%b stb=%b we=%b sel=%h ia=%b ie=%b da=%b de=%b want all 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, iport_ack_o, iport_err_o, dport_ack_o, dport_err_o);
        end
        n_checks++;
        if ({wb_addr_o, wb_dat_o, iport_rdata_o, dport_rdata_o} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h dat=%h irdata=%h drdata=%h want all 0",
                     wb_addr_o, wb_dat_o, iport_rdata_o, dport_rdata_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        iport_req_i  = 1'b1;
        iport_addr_i = 32'h100;
        tick();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0}) begin
            n_fail++;
            $display("FAIL fetch_bus: got cyc=%b stb=%b we=%b sel=%h addr=%h dat=%h want 1 1 0 f 00000100 00000000",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o);
        end
        n_checks++;
        if (iport_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_early_ack: got %b want 0", iport_ack_o);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0013;
        tick();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({iport_ack_o, iport_err_o, dport_ack_o, wb_cyc_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL fetch_pulse: got ia=%b ie=%b da=%b cyc=%b want 1 0 0 0",
                     iport_ack_o, iport_err_o, dport_ack_o, wb_cyc_o);
        end
        n_checks++;
        if (iport_rdata_o !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_rdata: got %h want 00000013", iport_rdata_o);
        end
        iport_req_i = 1'b0;
        tick();
        n_checks++;
        if ({iport_ack_o, wb_cyc_o, iport_rdata_o} !== {1'b0, 1'b0, 32'h13}) begin
            n_fail++;
            $display("FAIL fetch_after: got ia=%b cyc=%b rdata=%h want 0 0 00000013",
                     iport_ack_o, wb_cyc_o, iport_rdata_o);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        logic        exp_d;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        iport_req_i  = 1'b1;
        iport_addr_i = 32'h200;
        dport_req_i  = 1'b1;
        dport_addr_i = 32'h300;
        dport_we_i   = 1'b0;
        dport_sel_i  = 4'hF;
        dport_wdata_i = 32'h0;
        tick();
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2 == 0);
            exp_addr = exp_d ? 32'h300 : 32'h200;
            n_checks++;
            if ({wb_cyc_o, wb_addr_o} !== {1'b1, exp_addr}) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got cyc=%b addr=%h want 1 %h", t, wb_cyc_o, wb_addr_o, exp_addr);
            end
            wb_ack_i = 1'b1;
            wb_dat_i = 32'hA000_0000 + 32'(t);
            tick();
            wb_ack_i = 1'b0;
            n_checks++;
            if ({dport_ack_o, iport_ack_o} !== {exp_d, !exp_d}) begin
                n_fail++;
                $display("FAIL contention_pulse%0d: got da=%b ia=%b want %b %b", t, dport_ack_o, iport_ack_o, exp_d, !exp_d);
            end
            n_checks++;
            if ((exp_d ? dport_rdata_o : iport_rdata_o) !== 32'hA000_0000 + 32'(t)) begin
                n_fail++;
                $display("FAIL contention_rdata%0d: got d=%h i=%h want %h on the owner", t, dport_rdata_o, iport_rdata_o, 32'hA000_0000 + 32'(t));
            end
            if (t == 3) begin
                iport_req_i = 1'b0;
                dport_req_i = 1'b0;
            end
            tick();
            n_checks++;
            if (wb_cyc_o !== 1'b0) begin
                n_fail++;
                $display("FAIL contention_idle%0d: got cyc=%b want 0", t, wb_cyc_o);
            end
            if (t < 3) tick();
        end
        tick();
        n_checks++;
        if (wb_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_end: got cyc=%b want 0", wb_cyc_o);
        end
    endtask

    task automatic test_store_wait();
        dport_req_i   = 1'b1;
        dport_addr_i  = 32'h400;
        dport_wdata_i = 32'hDEAD_BEEF;
        dport_sel_i   = 4'h3;
        dport_we_i    = 1'b1;
        wb_dat_i      = 32'h5555_5555;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({wb_cyc_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o, dport_ack_o} !==
                {1'b1, 1'b1, 4'h3, 32'h400, 32'hDEAD_BEEF, 1'b0}) begin
                n_fail++;
                $display("FAIL store_bus%0d: got cyc=%b we=%b sel=%h addr=%h dat=%h da=%b want 1 1 3 00000400 deadbeef 0",
                         i, wb_cyc_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o, dport_ack_o);
            end
            // Change the request fields mid-transaction; the bus must keep the latched values.
            dport_addr_i  = 32'h999;
            dport_wdata_i = 32'h0;
            if (i == 3) wb_ack_i = 1'b1;
            tick();
        end
        wb_ack_i = 1'b0;
        n_checks++;
        if ({dport_ack_o, dport_err_o, wb_cyc_o, dport_rdata_o} !== {1'b1, 1'b0, 1'b0, 32'hA000_0002}) begin
            n_fail++;
            $display("FAIL store_done: got da=%b de=%b cyc=%b rdata=%h want 1 0 0 a0000002",
                     dport_ack_o, dport_err_o, wb_cyc_o, dport_rdata_o);
        end
        dport_req_i = 1'b0;
        dport_we_i  = 1'b0;
        tick();
        n_checks++;
        if (dport_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL store_single_pulse: got %b want 0", dport_ack_o);
        end
    endtask

    task automatic test_err_with_ack();
        iport_req_i  = 1'b1;
        iport_addr_i = 32'h500;
        tick();
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'h0000_0BAD;
        tick();
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        n_checks++;
        if ({iport_err_o, iport_ack_o, wb_cyc_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL err_pulse: got ie=%b ia=%b cyc=%b want 1 0 0", iport_err_o, iport_ack_o, wb_cyc_o);
        end
        n_checks++;
        if (iport_rdata_o !== 32'hA000_0003) begin
            n_fail++;
            $display("FAIL err_rdata: got %h want a0000003", iport_rdata_o);
        end
        iport_req_i = 1'b0;
        tick();
        n_checks++;
        if (iport_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_single_pulse: got %b want 0", iport_err_o);
        end
    endtask

    task automatic test_timeout();
        int cyc_cnt;
        dport_req_i  = 1'b1;
        dport_addr_i = 32'h600;
        dport_we_i   = 1'b0;
        dport_sel_i  = 4'hF;
        tick();
        cyc_cnt = 0;
        for (int k = 0; k < 20 && wb_cyc_o === 1'b1; k++) begin
            if (dport_err_o !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_early_err: got de=%b at cycle %0d want 0", dport_err_o, k);
            end
            cyc_cnt++;
            tick();
        end
        n_checks++;
        if (cyc_cnt != 8) begin
            n_fail++;
            $display("FAIL timeout_cyc_len: got %0d cycles want 8", cyc_cnt);
        end
        n_checks++;
        if ({dport_err_o, dport_ack_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_pulse: got de=%b da=%b want 1 0", dport_err_o, dport_ack_o);
        end
        dport_req_i = 1'b0;
        wb_ack_i    = 1'b1;
        wb_dat_i    = 32'h7777_7777;
        tick();
        wb_ack_i = 1'b0;
        n_checks++;
        if ({dport_ack_o, dport_err_o, iport_ack_o, wb_cyc_o, dport_rdata_o} !== {4'b0000, 32'hA000_0002}) begin
            n_fail++;
            $display("FAIL timeout_late_ack: got da=%b de=%b ia=%b cyc=%b rdata=%h want 0 0 0 0 a0000002",
                     dport_ack_o, dport_err_o, iport_ack_o, wb_cyc_o, dport_rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit saw_pulse;
        dport_req_i  = 1'b1;
        dport_addr_i = 32'h700;
        dport_we_i   = 1'b0;
        tick();
        n_checks++;
        if (wb_cyc_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_open: got cyc=%b want 1", wb_cyc_o);
        end
        tick();
        rst_i = 1'b1;
        tick();
        n_checks++;
        if ({wb_cyc_o, dport_ack_o, dport_err_o, iport_ack_o, iport_err_o} !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_abort: got cyc=%b da=%b de=%b ia=%b ie=%b want all 0",
                     wb_cyc_o, dport_ack_o, dport_err_o, iport_ack_o, iport_err_o);
        end
        rst_i = 1'b0;
        dport_req_i = 1'b0;
        saw_pulse = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (dport_ack_o | dport_err_o | iport_ack_o | iport_err_o) saw_pulse = 1'b1;
        end
        n_checks++;
        if (saw_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_pulse: got pulse=%b want 0", saw_pulse);
        end
        iport_req_i  = 1'b1;
        iport_addr_i = 32'h800;
        dport_req_i  = 1'b1;
        dport_addr_i = 32'h900;
        tick();
        n_checks++;
        if ({wb_cyc_o, wb_addr_o} !== {1'b1, 32'h900}) begin
            n_fail++;
            $display("FAIL rstmid_data_first: got cyc=%b addr=%h want 1 00000900", wb_cyc_o, wb_addr_o);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1111_2222;
        tick();
        wb_ack_i = 1'b0;
        iport_req_i = 1'b0;
        dport_req_i = 1'b0;
        n_checks++;
        if ({dport_ack_o, dport_rdata_o} !== {1'b1, 32'h1111_2222}) begin
            n_fail++;
            $display("FAIL rstmid_load: got da=%b rdata=%h want 1 11112222", dport_ack_o, dport_rdata_o);
        end
        tick();
    endtask

    initial begin
        rst_i = 1'b1;
        iport_req_i = 1'b0;
        iport_addr_i = 32'h0;
        dport_req_i = 1'b0;
        dport_addr_i = 32'h0;
        dport_wdata_i = 32'h0;
        dport_sel_i = 4'h0;
        dport_we_i = 1'b0;
        wb_dat_i = 32'h0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        #1;
        test_reset();
        test_single_fetch();
        test_contention();
        test_store_wait();
        test_err_with_ack();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
